bcd_lap_stopwatch: RTL and testbench



---
 rtl/bcd_sw_pkg.sv | 28 ++
 rtl/bcd_lap_stopwatch_if.sv | 35 +++
 rtl/bcd_time_step.sv | 68 ++++++
 rtl/bcd_lap_stopwatch.sv | 131 +++++++++++++
 tb/tb_bcd_lap_stopwatch.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/bcd_sw_pkg.sv
// Shared types, state encoding and BCD field layout for the hh:mm:ss lap stopwatch.
package bcd_sw_pkg;

    typedef logic [23:0] bcd_time_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } sw_state_e;

    localparam int HR_T_LSB  = 20;
    localparam int HR_O_LSB  = 16;
    localparam int MIN_T_LSB = 12;
    localparam int MIN_O_LSB = 8;
    localparam int SEC_T_LSB = 4;
    localparam int SEC_O_LSB = 0;

    function automatic logic time_valid(input bcd_time_t t, input int hr_max);
        int hours;
        hours = int'(t[HR_T_LSB +: 4]) * 10 + int'(t[HR_O_LSB +: 4]);
        return (t[HR_T_LSB  +: 4] <= 4'd9) && (t[HR_O_LSB  +: 4] <= 4'd9) &&
               (t[MIN_T_LSB +: 4] <= 4'd5) && (t[MIN_O_LSB +: 4] <= 4'd9) &&
               (t[SEC_T_LSB +: 4] <= 4'd5) && (t[SEC_O_LSB +: 4] <= 4'd9) &&
               (hours <= hr_max);
    endfunction

endpackage

// File: rtl/bcd_lap_stopwatch_if.sv
// Command, preset and display/lap signals between the button front end and the stopwatch.
interface bcd_lap_stopwatch_if
    import bcd_sw_pkg::*;
#(
    parameter int LAP_DEPTH = 4
);
    localparam int CW = $clog2(LAP_DEPTH + 1);

    logic            start;
    logic            stop;
    logic            clr;
    logic            lap;
    logic            dir;
    logic            load;
    bcd_time_t       load_time;
    logic            lap_rd;
    bcd_time_t       cnt_time;
    bcd_time_t       lap_time;
    logic            lap_valid;
    logic [CW-1:0]   lap_count;
    logic            lap_ovf;
    logic            done;
    logic            load_err;
    logic [1:0]      state;

    modport master (
        output start, stop, clr, lap, dir, load, load_time, lap_rd,
        input  cnt_time, lap_time, lap_valid, lap_count, lap_ovf, done, load_err, state
    );

    modport slave (
        input  start, stop, clr, lap, dir, load, load_time, lap_rd,
        output cnt_time, lap_time, lap_valid, lap_count, lap_ovf, done, load_err, state
    );
endinterface

// File: rtl/bcd_time_step.sv
// Combinational +/-1 second step of a BCD hh:mm:ss value; down-step saturates at zero.
module bcd_time_step
    import bcd_sw_pkg::*;
#(
    parameter int HR_MAX = 23
) (
    input  bcd_time_t time_i,
    input  logic      down_i,
    output bcd_time_t time_o,
    output logic      zero_o
);
    localparam logic [3:0] HR_MAX_T = 4'(HR_MAX / 10);
    localparam logic [3:0] HR_MAX_O = 4'(HR_MAX % 10);

    logic [3:0] d0, d1, d2, d3, d4, d5;
    logic [3:0] n0, n1, n2, n3, n4, n5;
    logic       c0, c1, c2, c3;

    assign d0 = time_i[SEC_O_LSB +: 4];
    assign d1 = time_i[SEC_T_LSB +: 4];
    assign d2 = time_i[MIN_O_LSB +: 4];
    assign d3 = time_i[MIN_T_LSB +: 4];
    assign d4 = time_i[HR_O_LSB  +: 4];
    assign d5 = time_i[HR_T_LSB  +: 4];
    assign zero_o = (time_i == '0);

    always_comb begin
        n0 = d0; n1 = d1; n2 = d2; n3 = d3; n4 = d4; n5 = d5;
        c0 = 1'b0; c1 = 1'b0; c2 = 1'b0; c3 = 1'b0;
        if (!down_i) begin
            c0 = (d0 == 4'd9);
            n0 = c0 ? 4'd0 : d0 + 4'd1;
            c1 = c0 && (d1 == 4'd5);
            if (c0) n1 = (d1 == 4'd5) ? 4'd0 : d1 + 4'd1;
            c2 = c1 && (d2 == 4'd9);
            if (c1) n2 = (d2 == 4'd9) ? 4'd0 : d2 + 4'd1;
            c3 = c2 && (d3 == 4'd5);
            if (c2) n3 = (d3 == 4'd5) ? 4'd0 : d3 + 4'd1;
            if (c3) begin
                if (d5 == HR_MAX_T && d4 == HR_MAX_O) begin
                    n4 = 4'd0;
                    n5 = 4'd0;
                end else if (d4 == 4'd9) begin
                    n4 = 4'd0;
                    n5 = d5 + 4'd1;
                end else begin
                    n4 = d4 + 4'd1;
                end
            end
        end else if (!zero_o) begin
            // Non-zero input guarantees the borrow chain stops before the top digit underflows.
            c0 = (d0 == 4'd0);
            n0 = c0 ? 4'd9 : d0 - 4'd1;
            c1 = c0 && (d1 == 4'd0);
            if (c0) n1 = (d1 == 4'd0) ? 4'd5 : d1 - 4'd1;
            c2 = c1 && (d2 == 4'd0);
            if (c1) n2 = (d2 == 4'd0) ? 4'd9 : d2 - 4'd1;
            c3 = c2 && (d3 == 4'd0);
            if (c2) n3 = (d3 == 4'd0) ? 4'd5 : d3 - 4'd1;
            if (c3) begin
                n4 = (d4 == 4'd0) ? 4'd9 : d4 - 4'd1;
                if (d4 == 4'd0) n5 = d5 - 4'd1;
            end
        end
    end

    assign time_o = {n5, n4, n3, n2, n1, n0};
endmodule

// File: rtl/bcd_lap_stopwatch.sv
// hh:mm:ss BCD stopwatch/timer with tick prescaler, up/down mode and a lap FIFO.
module bcd_lap_stopwatch
    import bcd_sw_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int LAP_DEPTH = 4,
    parameter int HR_MAX    = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_lap_stopwatch_if.slave    sw
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam int CW = $clog2(LAP_DEPTH + 1);

    sw_state_e     state_q, state_d;
    bcd_time_t     cnt_q, cnt_d, step_time;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_q, done_d, load_err_q, load_err_d;
    logic          cnt_zero, tick, start_ok;

    bcd_time_t     mem_q [LAP_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic          push, pop, full, push_ok;

    bcd_time_step #(.HR_MAX(HR_MAX)) u_step (
        .time_i (cnt_q),
        .down_i (sw.dir),
        .time_o (step_time),
        .zero_o (cnt_zero)
    );

    assign tick     = (state_q == ST_RUN) && (presc_q == PW'(TICK_DIV - 1));
    assign start_ok = sw.start && !sw.stop && !(sw.dir && cnt_zero);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        presc_d    = presc_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;
        if (sw.clr) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            presc_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start_ok) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                end
                ST_RUN: begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (sw.stop) state_d = ST_PAUSE;
                    if (tick) begin
                        cnt_d = step_time;
                        if (sw.dir && !cnt_zero && step_time == '0) begin
                            done_d  = 1'b1;
                            state_d = ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: if (start_ok) state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
            if (sw.load && state_q != ST_RUN) begin
                if (time_valid(sw.load_time, HR_MAX)) cnt_d = sw.load_time;
                else                                  load_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            presc_q    <= '0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            presc_q    <= presc_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    // A full FIFO still accepts a push when a read frees a slot in the same cycle.
    assign full    = (count_q == CW'(LAP_DEPTH));
    assign push    = sw.lap && !sw.clr && (state_q != ST_IDLE);
    assign pop     = sw.lap_rd && !sw.clr && (count_q != '0);
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAP_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else if (sw.clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= cnt_q;
                wr_ptr_q <= (wr_ptr_q == AW'(LAP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_q <= (rd_ptr_q == AW'(LAP_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            if (push_ok && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push_ok) count_q <= count_q - 1'b1;
            if (push && !push_ok) ovf_q <= 1'b1;
        end
    end

    assign sw.cnt_time  = cnt_q;
    assign sw.lap_valid = (count_q != '0);
    assign sw.lap_time  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign sw.lap_count = count_q;
    assign sw.lap_ovf   = ovf_q;
    assign sw.done      = done_q;
    assign sw.load_err  = load_err_q;
    assign sw.state     = state_q;
endmodule

// File: tb/tb_bcd_lap_stopwatch.sv
// Scenario bench for bcd_lap_stopwatch with TICK_DIV=4, LAP_DEPTH=4, HR_MAX=23.
module tb_bcd_lap_stopwatch;
    import bcd_sw_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   done_cnt = 0;
    bcd_time_t lap_q[$];

    bcd_lap_stopwatch_if #(.LAP_DEPTH(4)) sw_if ();

    bcd_lap_stopwatch #(.TICK_DIV(4), .LAP_DEPTH(4), .HR_MAX(23)) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (sw_if.done === 1'b1) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit expired, simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(); sw_if.start = 1'b1; step(); sw_if.start = 1'b0; endtask
    task automatic pulse_stop();  sw_if.stop  = 1'b1; step(); sw_if.stop  = 1'b0; endtask
    task automatic pulse_clr();   sw_if.clr   = 1'b1; step(); sw_if.clr   = 1'b0; endtask
    task automatic pulse_lap();   sw_if.lap   = 1'b1; step(); sw_if.lap   = 1'b0; endtask
    task automatic pulse_load(input bcd_time_t t);
        sw_if.load_time = t; sw_if.load = 1'b1; step(); sw_if.load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_tests++; if (sw_if.state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b want 00", sw_if.state); end
        n_tests++; if (sw_if.cnt_time !== 24'h000000) begin n_fail++; $display("FAIL reset_cnt: got %h want 000000", sw_if.cnt_time); end
        n_tests++; if ({sw_if.lap_valid, sw_if.lap_count, sw_if.lap_ovf, sw_if.done, sw_if.load_err} !== 7'b0)
            begin n_fail++; $display("FAIL reset_flags: got v%b c%0d o%b d%b e%b want all 0", sw_if.lap_valid, sw_if.lap_count, sw_if.lap_ovf, sw_if.done, sw_if.load_err); end
        n_tests++; if (sw_if.lap_time !== 24'h000000) begin n_fail++; $display("FAIL reset_lap_time: got %h want 000000", sw_if.lap_time); end
        #3 rst = 1'b0;
        step();
    endtask

    task automatic test_count_up();
        sw_if.dir = 1'b0;
        pulse_start();
        repeat (240) step();
        n_tests++; if (sw_if.cnt_time !== 24'h000100) begin n_fail++; $display("FAIL up_240: got %h want 000100", sw_if.cnt_time); end
        n_tests++; if (sw_if.state !== 2'b01) begin n_fail++; $display("FAIL up_state_run: got %b want 01", sw_if.state); end
        pulse_stop();
        repeat (20) step();
        n_tests++; if (sw_if.cnt_time !== 24'h000100) begin n_fail++; $display("FAIL pause_hold: got %h want 000100", sw_if.cnt_time); end
        n_tests++; if (sw_if.state !== 2'b10) begin n_fail++; $display("FAIL pause_state: got %b want 10", sw_if.state); end
    endtask

    task automatic test_hr_wrap();
        pulse_load(24'h235958);
        n_tests++; if (sw_if.cnt_time !== 24'h235958) begin n_fail++; $display("FAIL wrap_load: got %h want 235958", sw_if.cnt_time); end
        n_tests++; if (sw_if.state !== 2'b10) begin n_fail++; $display("FAIL wrap_load_state: got %b want 10", sw_if.state); end
        done_cnt = 0;
        // Prescaler resumes at 1 from the pause, so the two ticks land 3 and 7 cycles on.
        pulse_start();
        repeat (3) step();
        n_tests++; if (sw_if.cnt_time !== 24'h235959) begin n_fail++; $display("FAIL wrap_first_tick: got %h want 235959", sw_if.cnt_time); end
        repeat (4) step();
        n_tests++; if (sw_if.cnt_time !== 24'h000000) begin n_fail++; $display("FAIL wrap_zero: got %h want 000000", sw_if.cnt_time); end
        n_tests++; if (done_cnt !== 0) begin n_fail++; $display("FAIL wrap_no_done: got %0d done pulses want 0", done_cnt); end
        pulse_stop();
    endtask

    task automatic test_count_down();
        pulse_clr();
        sw_if.dir = 1'b1;
        pulse_start();
        n_tests++; if (sw_if.state !== 2'b00) begin n_fail++; $display("FAIL down_start_zero_idle: got %b want 00", sw_if.state); end
        pulse_load(24'h000002);
        done_cnt = 0;
        pulse_start();
        repeat (4) step();
        n_tests++; if (sw_if.cnt_time !== 24'h000001) begin n_fail++; $display("FAIL down_one: got %h want 000001", sw_if.cnt_time); end
        n_tests++; if (sw_if.done !== 1'b0) begin n_fail++; $display("FAIL down_early_done: got %b want 0", sw_if.done); end
        repeat (4) step();
        n_tests++; if (sw_if.cnt_time !== 24'h000000) begin n_fail++; $display("FAIL down_zero: got %h want 000000", sw_if.cnt_time); end
        n_tests++; if (sw_if.done !== 1'b1) begin n_fail++; $display("FAIL down_done: got %b want 1", sw_if.done); end
        n_tests++; if (sw_if.state !== 2'b10) begin n_fail++; $display("FAIL down_pause: got %b want 10", sw_if.state); end
        repeat (10) step();
        n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL down_done_once: got %0d pulses want 1", done_cnt); end
        pulse_start();
        n_tests++; if (sw_if.state !== 2'b10) begin n_fail++; $display("FAIL down_restart_ignored: got %b want 10", sw_if.state); end
        sw_if.dir = 1'b0;
    endtask

    task automatic test_lap_fifo();
        bcd_time_t vals[5] = '{24'h000010, 24'h000220, 24'h013000, 24'h100005, 24'h121314};
        bcd_time_t exp_t;
        pulse_clr();
        pulse_lap();
        n_tests++; if (sw_if.lap_count !== 3'd0) begin n_fail++; $display("FAIL lap_idle_ignored: got %0d want 0", sw_if.lap_count); end
        pulse_start();
        pulse_stop();
        lap_q.delete();
        for (int i = 0; i < 5; i++) begin
            pulse_load(vals[i]);
            if (lap_q.size() < 4) lap_q.push_back(vals[i]);
            pulse_lap();
        end
        n_tests++; if (sw_if.lap_count !== 3'd4) begin n_fail++; $display("FAIL lap_count_full: got %0d want 4", sw_if.lap_count); end
        n_tests++; if (sw_if.lap_ovf !== 1'b1) begin n_fail++; $display("FAIL lap_ovf: got %b want 1", sw_if.lap_ovf); end
        for (int i = 0; i < 4; i++) begin
            exp_t = lap_q.pop_front();
            n_tests++; if (sw_if.lap_time !== exp_t) begin n_fail++; $display("FAIL lap_order_%0d: got %h want %h", i, sw_if.lap_time, exp_t); end
            sw_if.lap_rd = 1'b1; step(); sw_if.lap_rd = 1'b0;
        end
        n_tests++; if (sw_if.lap_valid !== 1'b0) begin n_fail++; $display("FAIL lap_drained_valid: got %b want 0", sw_if.lap_valid); end
        sw_if.lap_rd = 1'b1; step(); sw_if.lap_rd = 1'b0;
        n_tests++; if (sw_if.lap_count !== 3'd0) begin n_fail++; $display("FAIL lap_rd_empty: got %0d want 0", sw_if.lap_count); end
    endtask

    task automatic test_back_to_back();
        bcd_time_t vals[5] = '{24'h000101, 24'h020202, 24'h030303, 24'h040404, 24'h000530};
        bcd_time_t exp_t;
        pulse_clr();
        pulse_start();
        pulse_stop();
        lap_q.delete();
        for (int i = 0; i < 4; i++) begin
            pulse_load(vals[i]);
            lap_q.push_back(vals[i]);
            pulse_lap();
        end
        pulse_load(vals[4]);
        void'(lap_q.pop_front());
        lap_q.push_back(vals[4]);
        sw_if.lap = 1'b1; sw_if.lap_rd = 1'b1; step(); sw_if.lap = 1'b0; sw_if.lap_rd = 1'b0;
        n_tests++; if (sw_if.lap_count !== 3'd4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", sw_if.lap_count); end
        n_tests++; if (sw_if.lap_ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_no_ovf: got %b want 0", sw_if.lap_ovf); end
        for (int i = 0; i < 4; i++) begin
            exp_t = lap_q.pop_front();
            n_tests++; if (sw_if.lap_time !== exp_t) begin n_fail++; $display("FAIL b2b_order_%0d: got %h want %h", i, sw_if.lap_time, exp_t); end
            sw_if.lap_rd = 1'b1; step(); sw_if.lap_rd = 1'b0;
        end
    endtask

    task automatic test_clr_override();
        pulse_load(24'h000045);
        pulse_start();
        pulse_lap();
        pulse_lap();
        sw_if.clr = 1'b1; sw_if.stop = 1'b1; sw_if.lap = 1'b1;
        step();
        sw_if.clr = 1'b0; sw_if.stop = 1'b0; sw_if.lap = 1'b0;
        n_tests++; if (sw_if.state !== 2'b00) begin n_fail++; $display("FAIL clr_state: got %b want 00", sw_if.state); end
        n_tests++; if (sw_if.cnt_time !== 24'h000000) begin n_fail++; $display("FAIL clr_cnt: got %h want 000000", sw_if.cnt_time); end
        n_tests++; if ({sw_if.lap_valid, sw_if.lap_count, sw_if.lap_ovf} !== 5'b0)
            begin n_fail++; $display("FAIL clr_fifo: got v%b c%0d o%b want 0/0/0", sw_if.lap_valid, sw_if.lap_count, sw_if.lap_ovf); end
        lap_q.delete();
    endtask

    task automatic test_load_err();
        pulse_clr();
        pulse_load(24'h010203);
        pulse_start();
        pulse_stop();
        pulse_load(24'h126000);
        n_tests++; if (sw_if.load_err !== 1'b1) begin n_fail++; $display("FAIL load_err_min: got %b want 1", sw_if.load_err); end
        n_tests++; if (sw_if.cnt_time !== 24'h010203) begin n_fail++; $display("FAIL load_err_cnt: got %h want 010203", sw_if.cnt_time); end
        step();
        n_tests++; if (sw_if.load_err !== 1'b0) begin n_fail++; $display("FAIL load_err_pulse: got %b want 0", sw_if.load_err); end
        pulse_load(24'h240000);
        n_tests++; if (sw_if.load_err !== 1'b1) begin n_fail++; $display("FAIL load_err_hr: got %b want 1", sw_if.load_err); end
        pulse_load(24'h230000);
        n_tests++; if (sw_if.cnt_time !== 24'h230000) begin n_fail++; $display("FAIL load_hrmax_ok: got %h want 230000", sw_if.cnt_time); end
        pulse_load(24'h010203);
        pulse_start();
        pulse_load(24'h120000);
        n_tests++; if (sw_if.cnt_time !== 24'h010203) begin n_fail++; $display("FAIL load_run_ignored: got %h want 010203", sw_if.cnt_time); end
        n_tests++; if (sw_if.load_err !== 1'b0) begin n_fail++; $display("FAIL load_run_no_err: got %b want 0", sw_if.load_err); end
    endtask

    task automatic test_async_rst();
        pulse_lap();
        n_tests++; if (sw_if.lap_count !== 3'd1) begin n_fail++; $display("FAIL rst_pre_lap: got %0d want 1", sw_if.lap_count); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (sw_if.state !== 2'b00) begin n_fail++; $display("FAIL async_rst_state: got %b want 00", sw_if.state); end
        n_tests++; if (sw_if.cnt_time !== 24'h000000) begin n_fail++; $display("FAIL async_rst_cnt: got %h want 000000", sw_if.cnt_time); end
        n_tests++; if ({sw_if.lap_valid, sw_if.lap_count} !== 4'b0) begin n_fail++; $display("FAIL async_rst_fifo: got v%b c%0d want 0", sw_if.lap_valid, sw_if.lap_count); end
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        sw_if.start = 1'b0; sw_if.stop = 1'b0; sw_if.clr = 1'b0; sw_if.lap = 1'b0;
        sw_if.dir = 1'b0; sw_if.load = 1'b0; sw_if.load_time = '0; sw_if.lap_rd = 1'b0;
        test_reset();
        test_count_up();
        test_hr_wrap();
        test_count_down();
        test_lap_fifo();
        test_back_to_back();
        test_clr_override();
        test_load_err();
        test_async_rst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
